// File: rtl/eth_phy_pkg.sv
// Shared constants and types for the multi-lane 64b/66b RX block synchroniser.
// Lanes treat the two legal sync headers identically; anything else counts as a header error.
package eth_phy_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  typedef enum logic [1:0] {
    ST_UNLOCKED  = 2'd0,
    ST_LOCKED    = 2'd1,
    ST_SLIP_HIGH = 2'd2,
    ST_SLIP_LOW  = 2'd3
  } lock_state_e;

  function automatic logic hdr_is_valid(input logic [1:0] hdr);
    return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/eth_phy_rx_block_sync_multi_if.sv
// Bundle between the SERDES/gearbox, the block synchroniser and the downstream decoder.
// slave = synchroniser side, master = the gearbox/decoder (or a bench) driving headers.
interface eth_phy_rx_block_sync_multi_if #(
  parameter int LANES     = 4,
  parameter int HDR_WIDTH = 2
);

  logic [LANES*HDR_WIDTH-1:0] serdes_rx_hdr;
  logic [LANES-1:0]           serdes_rx_hdr_valid;
  logic [LANES-1:0]           serdes_rx_bitslip;
  logic [LANES-1:0]           serdes_rx_reset_req;
  logic [LANES-1:0]           rx_block_lock;
  logic [LANES-1:0]           rx_high_ber;
  logic [LANES-1:0]           rx_status;
  logic                       rx_all_lock;
  logic [LANES-1:0]           rx_bad_hdr;

  modport slave (
    input  serdes_rx_hdr,
    input  serdes_rx_hdr_valid,
    output serdes_rx_bitslip,
    output serdes_rx_reset_req,
    output rx_block_lock,
    output rx_high_ber,
    output rx_status,
    output rx_all_lock,
    output rx_bad_hdr
  );

  modport master (
    output serdes_rx_hdr,
    output serdes_rx_hdr_valid,
    input  serdes_rx_bitslip,
    input  serdes_rx_reset_req,
    input  rx_block_lock,
    input  rx_high_ber,
    input  rx_status,
    input  rx_all_lock,
    input  rx_bad_hdr
  );

endinterface

// File: rtl/eth_phy_rx_lane_sync.sv
// One 66b lane: lock FSM with bitslip timing, BER counter and SERDES reset-request counter.
//   state        | meaning
//   ST_UNLOCKED  | hunting, counting consecutive valid headers toward lock
//   ST_LOCKED    | block lock held, windowed error count watches for loss of lock
//   ST_SLIP_HIGH | bitslip request asserted to the SERDES
//   ST_SLIP_LOW  | bitslip released, headers ignored while the gearbox settles
module eth_phy_rx_lane_sync
  import eth_phy_pkg::*;
#(
  parameter int LOCK_COUNT          = 64,
  parameter int UNLOCK_WINDOW       = 64,
  parameter int UNLOCK_ERRORS       = 16,
  parameter int BITSLIP_HIGH_CYCLES = 1,
  parameter int BITSLIP_LOW_CYCLES  = 8,
  parameter int BER_ERRORS          = 16,
  parameter int RESET_REQ_WINDOWS   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] hdr_i,
  input  logic       hdr_valid_i,
  input  logic       timer_wrap_i,
  output logic       bitslip_o,
  output logic       reset_req_o,
  output logic       block_lock_o,
  output logic       high_ber_o,
  output logic       bad_hdr_o
);

  localparam int GOOD_W   = $clog2(LOCK_COUNT + 1);
  localparam int HCNT_W   = $clog2(UNLOCK_WINDOW + 1);
  localparam int ERR_W    = $clog2(UNLOCK_ERRORS + 1);
  localparam int BER_W    = $clog2(BER_ERRORS + 1);
  localparam int WIN_W    = $clog2(RESET_REQ_WINDOWS + 1);
  localparam int SLIP_MAX = (BITSLIP_HIGH_CYCLES > BITSLIP_LOW_CYCLES) ?
                            BITSLIP_HIGH_CYCLES : BITSLIP_LOW_CYCLES;
  localparam int SLIP_W   = $clog2(SLIP_MAX + 1);

  localparam logic [GOOD_W-1:0] LOCK_LIM     = GOOD_W'(LOCK_COUNT);
  localparam logic [HCNT_W-1:0] WIN_LIM      = HCNT_W'(UNLOCK_WINDOW);
  localparam logic [ERR_W-1:0]  ERR_LIM      = ERR_W'(UNLOCK_ERRORS);
  localparam logic [BER_W-1:0]  BER_LIM      = BER_W'(BER_ERRORS);
  localparam logic [WIN_W-1:0]  REQ_LIM      = WIN_W'(RESET_REQ_WINDOWS);
  localparam logic [SLIP_W-1:0] SLIP_HIGH_LD = SLIP_W'(BITSLIP_HIGH_CYCLES - 1);
  localparam logic [SLIP_W-1:0] SLIP_LOW_LD  = SLIP_W'(BITSLIP_LOW_CYCLES - 1);

  lock_state_e       state_q, state_d;
  logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
  logic [HCNT_W-1:0] hdr_cnt_q, hdr_cnt_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
  logic [SLIP_W-1:0] slip_cnt_q, slip_cnt_d;
  logic [BER_W-1:0]  ber_cnt_q, ber_cnt_d;
  logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
  logic              high_ber_q, high_ber_d;
  logic              reset_req_q, reset_req_d;
  logic              block_lock_q, block_lock_d;
  logic              bitslip_q, bitslip_d;
  logic              bad_hdr_q, bad_hdr_d;

  logic              sample;
  logic              bad;
  logic [GOOD_W-1:0] good_inc;
  logic [HCNT_W-1:0] hdr_inc;
  logic [ERR_W-1:0]  err_inc;
  logic [BER_W-1:0]  ber_base;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_UNLOCKED;
      good_cnt_q   <= '0;
      hdr_cnt_q    <= '0;
      err_cnt_q    <= '0;
      slip_cnt_q   <= '0;
      ber_cnt_q    <= '0;
      win_cnt_q    <= '0;
      high_ber_q   <= 1'b0;
      reset_req_q  <= 1'b0;
      block_lock_q <= 1'b0;
      bitslip_q    <= 1'b0;
      bad_hdr_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      good_cnt_q   <= good_cnt_d;
      hdr_cnt_q    <= hdr_cnt_d;
      err_cnt_q    <= err_cnt_d;
      slip_cnt_q   <= slip_cnt_d;
      ber_cnt_q    <= ber_cnt_d;
      win_cnt_q    <= win_cnt_d;
      high_ber_q   <= high_ber_d;
      reset_req_q  <= reset_req_d;
      block_lock_q <= block_lock_d;
      bitslip_q    <= bitslip_d;
      bad_hdr_q    <= bad_hdr_d;
    end
  end

  // Lock FSM and slip timing
  always_comb begin
    sample     = hdr_valid_i && (state_q != ST_SLIP_LOW);
    bad        = sample && !hdr_is_valid(hdr_i);
    good_inc   = good_cnt_q + GOOD_W'(1);
    hdr_inc    = hdr_cnt_q + HCNT_W'(1);
    err_inc    = err_cnt_q + ERR_W'(bad);
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    hdr_cnt_d  = hdr_cnt_q;
    err_cnt_d  = err_cnt_q;
    slip_cnt_d = slip_cnt_q;

    unique case (state_q)
      ST_UNLOCKED: begin
        if (sample) begin
          if (bad) begin
            good_cnt_d = '0;
            slip_cnt_d = SLIP_HIGH_LD;
            state_d    = ST_SLIP_HIGH;
          end else if (good_inc == LOCK_LIM) begin
            good_cnt_d = '0;
            hdr_cnt_d  = '0;
            err_cnt_d  = '0;
            state_d    = ST_LOCKED;
          end else begin
            good_cnt_d = good_inc;
          end
        end
      end
      ST_LOCKED: begin
        if (sample) begin
          // The error test comes first so a window-closing error still unlocks.
          if (err_inc == ERR_LIM) begin
            hdr_cnt_d  = '0;
            err_cnt_d  = '0;
            slip_cnt_d = SLIP_HIGH_LD;
            state_d    = ST_SLIP_HIGH;
          end else if (hdr_inc == WIN_LIM) begin
            hdr_cnt_d = '0;
            err_cnt_d = '0;
          end else begin
            hdr_cnt_d = hdr_inc;
            err_cnt_d = err_inc;
          end
        end
      end
      ST_SLIP_HIGH: begin
        if (slip_cnt_q == '0) begin
          slip_cnt_d = SLIP_LOW_LD;
          state_d    = ST_SLIP_LOW;
        end else begin
          slip_cnt_d = slip_cnt_q - SLIP_W'(1);
        end
      end
      ST_SLIP_LOW: begin
        if (slip_cnt_q == '0) begin
          good_cnt_d = '0;
          state_d    = ST_UNLOCKED;
        end else begin
          slip_cnt_d = slip_cnt_q - SLIP_W'(1);
        end
      end
      default: state_d = ST_UNLOCKED;
    endcase
  end

  // BER window: an error on the wrap cycle lands in the new window.
  always_comb begin
    ber_base   = timer_wrap_i ? '0 : ber_cnt_q;
    ber_cnt_d  = ber_base;
    high_ber_d = high_ber_q;
    if (bad && (ber_base != BER_LIM)) begin
      ber_cnt_d = ber_base + BER_W'(1);
    end
    if (timer_wrap_i && (ber_cnt_q != BER_LIM)) begin
      high_ber_d = 1'b0;
    end
    if (ber_cnt_d == BER_LIM) begin
      high_ber_d = 1'b1;
    end
  end

  always_comb begin
    win_cnt_d   = win_cnt_q;
    reset_req_d = 1'b0;
    if (state_d == ST_LOCKED) begin
      win_cnt_d = '0;
    end else if (timer_wrap_i && !block_lock_q) begin
      if (win_cnt_q + WIN_W'(1) == REQ_LIM) begin
        win_cnt_d   = '0;
        reset_req_d = 1'b1;
      end else begin
        win_cnt_d = win_cnt_q + WIN_W'(1);
      end
    end
  end

  assign block_lock_d = (state_d == ST_LOCKED);
  assign bitslip_d    = (state_d == ST_SLIP_HIGH);
  assign bad_hdr_d    = bad;

  assign bitslip_o    = bitslip_q;
  assign reset_req_o  = reset_req_q;
  assign block_lock_o = block_lock_q;
  assign high_ber_o   = high_ber_q;
  assign bad_hdr_o    = bad_hdr_q;

endmodule

// File: rtl/eth_phy_rx_block_sync_multi.sv
// Multi-lane 64b/66b block synchroniser: per-lane lock/BER logic plus the shared
// 125 us BER timer and the registered aggregate status outputs.
module eth_phy_rx_block_sync_multi
  import eth_phy_pkg::*;
#(
  parameter int LANES               = 4,
  parameter int HDR_WIDTH           = 2,
  parameter int LOCK_COUNT          = 64,
  parameter int UNLOCK_WINDOW       = 64,
  parameter int UNLOCK_ERRORS       = 16,
  parameter int BITSLIP_HIGH_CYCLES = 1,
  parameter int BITSLIP_LOW_CYCLES  = 8,
  parameter int COUNT_125US         = 19531,
  parameter int BER_ERRORS          = 16,
  parameter int RESET_REQ_WINDOWS   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  eth_phy_rx_block_sync_multi_if.slave  rx_if
);

  localparam int TMR_W = $clog2(COUNT_125US + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(COUNT_125US - 1);

  logic [TMR_W-1:0] timer_q, timer_d;
  logic             timer_wrap;
  logic [LANES-1:0] lane_bitslip;
  logic [LANES-1:0] lane_reset_req;
  logic [LANES-1:0] lane_lock;
  logic [LANES-1:0] lane_high_ber;
  logic [LANES-1:0] lane_bad_hdr;
  logic [LANES-1:0] rx_status_q, rx_status_d;
  logic             rx_all_lock_q, rx_all_lock_d;

  // Single free-running BER timer keeps every lane's window aligned.
  always_comb begin
    timer_wrap = (timer_q == TMR_LAST);
    timer_d    = timer_wrap ? '0 : timer_q + TMR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q       <= '0;
      rx_status_q   <= '0;
      rx_all_lock_q <= 1'b0;
    end else begin
      timer_q       <= timer_d;
      rx_status_q   <= rx_status_d;
      rx_all_lock_q <= rx_all_lock_d;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    eth_phy_rx_lane_sync #(
      .LOCK_COUNT          (LOCK_COUNT),
      .UNLOCK_WINDOW       (UNLOCK_WINDOW),
      .UNLOCK_ERRORS       (UNLOCK_ERRORS),
      .BITSLIP_HIGH_CYCLES (BITSLIP_HIGH_CYCLES),
      .BITSLIP_LOW_CYCLES  (BITSLIP_LOW_CYCLES),
      .BER_ERRORS          (BER_ERRORS),
      .RESET_REQ_WINDOWS   (RESET_REQ_WINDOWS)
    ) u_lane (
      .clk          (clk),
      .rst_n        (rst_n),
      .hdr_i        (rx_if.serdes_rx_hdr[HDR_WIDTH*i +: HDR_WIDTH]),
      .hdr_valid_i  (rx_if.serdes_rx_hdr_valid[i]),
      .timer_wrap_i (timer_wrap),
      .bitslip_o    (lane_bitslip[i]),
      .reset_req_o  (lane_reset_req[i]),
      .block_lock_o (lane_lock[i]),
      .high_ber_o   (lane_high_ber[i]),
      .bad_hdr_o    (lane_bad_hdr[i])
    );
  end

  assign rx_status_d   = lane_lock & ~lane_high_ber;
  assign rx_all_lock_d = &lane_lock;

  assign rx_if.serdes_rx_bitslip   = lane_bitslip;
  assign rx_if.serdes_rx_reset_req = lane_reset_req;
  assign rx_if.rx_block_lock       = lane_lock;
  assign rx_if.rx_high_ber         = lane_high_ber;
  assign rx_if.rx_bad_hdr          = lane_bad_hdr;
  assign rx_if.rx_status           = rx_status_q;
  assign rx_if.rx_all_lock         = rx_all_lock_q;

endmodule

// File: tb/tb_eth_phy_rx_block_sync_multi.sv
// Directed bench for the multi-lane block synchroniser, two lanes and a 200-clock BER window.
module tb_eth_phy_rx_block_sync_multi;

  localparam int LANES = 2;
  localparam int COUNT = 200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  int   e, sidx, nslip, nbad, nrr0, nrr1;
  logic anyhb, anybad, anyslip;

  always #5 clk = ~clk;

  eth_phy_rx_block_sync_multi_if #(.LANES(LANES), .HDR_WIDTH(2)) rx_if ();

  eth_phy_rx_block_sync_multi #(
    .LANES       (LANES),
    .HDR_WIDTH   (2),
    .COUNT_125US (COUNT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx_if (rx_if)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc);
    else passes++;
  endtask

  function automatic logic [1:0] vh(input int n);
    return n[0] ? 2'b01 : 2'b10;
  endfunction

  // Present headers, clock once, then settle 1 ns past the edge.
  task automatic drive(input logic [1:0] h0, input logic [1:0] h1, input logic [1:0] v);
    rx_if.serdes_rx_hdr       = {h1, h0};
    rx_if.serdes_rx_hdr_valid = v;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rx_if.serdes_rx_hdr       = '0;
    rx_if.serdes_rx_hdr_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: lane 0 locks after 64 headers, lane 1 slips every 10 clocks on 2'b00
    do_reset();
    check_val("rst_lock", rx_if.rx_block_lock, 0);
    check_val("rst_slip", rx_if.serdes_rx_bitslip, 0);
    nslip = 0;
    while (cyc < 63) begin
      drive(vh(cyc + 1), 2'b00, 2'b11);
      if (rx_if.serdes_rx_bitslip[1]) nslip++;
      if (cyc == 1) check_val("t1_slip_rise", rx_if.serdes_rx_bitslip, 2'b10);
      if (cyc == 1) check_val("t1_bad1", rx_if.rx_bad_hdr, 2'b10);
      if (cyc == 2) check_val("t1_slip_fall", rx_if.serdes_rx_bitslip, 2'b00);
    end
    check_val("t1_lock63", rx_if.rx_block_lock, 2'b00);
    drive(vh(64), 2'b00, 2'b11);
    if (rx_if.serdes_rx_bitslip[1]) nslip++;
    check_val("t1_lock64", rx_if.rx_block_lock, 2'b01);
    check_val("t1_all_lock", rx_if.rx_all_lock, 0);
    check_val("t1_status_lag", rx_if.rx_status, 2'b00);
    check_val("t1_slip_count", nslip, 7);
    drive(vh(65), 2'b00, 2'b11);
    check_val("t1_status", rx_if.rx_status, 2'b01);

    // 2: 16 errors in a window unlock; 1 clock high, 8 ignored clocks low
    repeat (15) drive(2'b00, 2'b00, 2'b01);
    check_val("t2_lock15", rx_if.rx_block_lock[0], 1);
    drive(2'b00, 2'b00, 2'b01);
    check_val("t2_unlock16", rx_if.rx_block_lock[0], 0);
    check_val("t2_slip_high", rx_if.serdes_rx_bitslip[0], 1);
    check_val("t2_bad16", rx_if.rx_bad_hdr[0], 1);
    check_val("t2_high_ber", rx_if.rx_high_ber[0], 1);
    drive(vh(0), 2'b00, 2'b01);
    check_val("t2_slip_low", rx_if.serdes_rx_bitslip[0], 0);
    anybad = 1'b0;
    anyslip = 1'b0;
    repeat (8) begin
      drive(2'b00, 2'b00, 2'b01);
      anybad  |= rx_if.rx_bad_hdr[0];
      anyslip |= rx_if.serdes_rx_bitslip[0];
    end
    check_val("t2_ignored_bad", anybad, 0);
    check_val("t2_ignored_slip", anyslip, 0);
    drive(2'b00, 2'b00, 2'b01);
    check_val("t2_reslip", rx_if.serdes_rx_bitslip[0], 1);
    check_val("t2_rebad", rx_if.rx_bad_hdr[0], 1);

    // 3: 15 errors per lock window (1-in-4 sampling) holds lock, then high_ber
    do_reset();
    while (cyc < 64) drive(vh(cyc + 1), 2'b00, 2'b01);
    nbad = 0;
    anyhb = 1'b0;
    while (cyc < 832) begin
      e = cyc + 1;
      if (e % 4 == 0) begin
        sidx = (e - 68) / 4;
        drive(((sidx % 64) < 15) ? 2'b00 : vh(e), 2'b00, 2'b01);
      end else begin
        drive(2'b00, 2'b00, 2'b00);
      end
      if (rx_if.rx_bad_hdr[0]) nbad++;
      anyhb |= rx_if.rx_high_ber[0];
    end
    check_val("t3_lock_held", rx_if.rx_block_lock[0], 1);
    check_val("t3_bad_count", nbad, 45);
    check_val("t3_no_high_ber", anyhb, 0);
    while (cyc < 896) begin
      e = cyc + 1;
      drive((e >= 882) ? 2'b00 : vh(e), 2'b00, 2'b01);
    end
    check_val("t3_lock_w4", rx_if.rx_block_lock[0], 1);
    check_val("t3_hb_15", rx_if.rx_high_ber[0], 0);
    drive(2'b00, 2'b00, 2'b01);
    check_val("t3_hb_set", rx_if.rx_high_ber[0], 1);
    check_val("t3_lock_keep", rx_if.rx_block_lock[0], 1);
    check_val("t3_status_lag", rx_if.rx_status[0], 1);
    drive(vh(0), 2'b00, 2'b01);
    check_val("t3_status_drop", rx_if.rx_status[0], 0);
    while (cyc < 1199) drive(vh(cyc + 1), 2'b00, 2'b01);
    check_val("t3_hb_held", rx_if.rx_high_ber[0], 1);
    drive(vh(0), 2'b00, 2'b01);
    check_val("t3_hb_clear", rx_if.rx_high_ber[0], 0);
    drive(vh(1), 2'b00, 2'b01);
    check_val("t3_status_back", rx_if.rx_status[0], 1);

    // 4: reset request after 4 unlocked windows; lane 0 locks early and never requests
    do_reset();
    nrr0 = 0;
    nrr1 = 0;
    while (cyc < 810) begin
      e = cyc + 1;
      drive(vh(e), 2'b00, (e > 300) ? 2'b11 : 2'b10);
      if (rx_if.serdes_rx_reset_req[0]) nrr0++;
      if (rx_if.serdes_rx_reset_req[1]) nrr1++;
      if (cyc == 799) check_val("t4_rr_799", rx_if.serdes_rx_reset_req, 2'b00);
      if (cyc == 800) check_val("t4_rr_800", rx_if.serdes_rx_reset_req, 2'b10);
    end
    check_val("t4_rr0_count", nrr0, 0);
    check_val("t4_rr1_count", nrr1, 1);
    check_val("t4_lock0", rx_if.rx_block_lock, 2'b01);

    // 5: 1-in-3 gapped valid; unsampled 2'b00 headers are ignored
    do_reset();
    anybad = 1'b0;
    while (cyc < 192) begin
      e = cyc + 1;
      if (e % 3 == 0) drive(vh(e), 2'b00, 2'b01);
      else drive(2'b00, 2'b00, 2'b00);
      anybad |= rx_if.rx_bad_hdr[0];
      if (cyc == 191) check_val("t5_lock191", rx_if.rx_block_lock[0], 0);
    end
    check_val("t5_lock192", rx_if.rx_block_lock[0], 1);
    check_val("t5_no_bad", anybad, 0);

    // 6: asynchronous reset during SLIP_HIGH, then a clean relock
    do_reset();
    while (cyc < 64) drive(2'b00, vh(cyc + 1), 2'b10);
    drive(2'b00, vh(0), 2'b11);
    check_val("t6_slip_pre", rx_if.serdes_rx_bitslip, 2'b01);
    check_val("t6_lock_pre", rx_if.rx_block_lock, 2'b10);
    check_val("t6_status_pre", rx_if.rx_status, 2'b10);
    rst_n = 1'b0;
    #1;
    check_val("t6_rst_slip", rx_if.serdes_rx_bitslip, 0);
    check_val("t6_rst_lock", rx_if.rx_block_lock, 0);
    check_val("t6_rst_status", rx_if.rx_status, 0);
    check_val("t6_rst_bad", rx_if.rx_bad_hdr, 0);
    check_val("t6_rst_all", rx_if.rx_all_lock, 0);
    do_reset();
    anyslip = 1'b0;
    while (cyc < 63) begin
      drive(vh(cyc + 1), 2'b00, 2'b01);
      anyslip |= rx_if.serdes_rx_bitslip[0];
    end
    check_val("t6_relock63", rx_if.rx_block_lock[0], 0);
    drive(vh(64), 2'b00, 2'b01);
    check_val("t6_relock64", rx_if.rx_block_lock[0], 1);
    check_val("t6_no_slip", anyslip, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
